// File: rtl/kf8288_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : kf8288_bus_arbiter
// Description : Hands system-bus ownership between the CPU (through the
//               8288 bus controller) and the DMA hold request. Every handover
//               step is taken on a cpu_clock rising edge seen in the fast
//               clock domain.
// Revision    : 1.0 - initial release
// ============================================================================
module kf8288_bus_arbiter #(
  parameter int HANDOVER_CYCLES = 2,   // ticks spent in RELEASE (1..15)
  parameter int RETURN_CYCLES   = 1,   // ticks spent in RECLAIM (1..15)
  parameter int DMA_TIMEOUT     = 0    // DMA ownership limit in ticks, 0 = off
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cpu_clock,
  input  logic [2:0] processor_status,
  input  logic       lock_n,
  input  logic       dma_hold_request,
  output logic       dma_hold_acknowledge,
  output logic       address_enable_n,
  output logic       command_enable,
  output logic       cpu_ready,
  output logic       dma_timeout,
  output logic [1:0] bus_state
);

  typedef enum logic [1:0] {
    ST_CPU_OWN = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DMA_OWN = 2'd2,
    ST_RECLAIM = 2'd3
  } state_t;

  localparam logic [3:0]  c_HANDOVER_LOAD = 4'(HANDOVER_CYCLES - 1);
  localparam logic [3:0]  c_RETURN_LOAD   = 4'(RETURN_CYCLES - 1);
  localparam logic [15:0] c_TIMEOUT       = 16'(DMA_TIMEOUT);
  localparam logic        c_TIMEOUT_EN    = (DMA_TIMEOUT != 0);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic        prev_cpu_clock_q;
  logic        passive_q;

  logic        w_tick;
  logic        w_passive_now;
  logic        w_bus_idle;

  assign w_tick        = ~prev_cpu_clock_q & cpu_clock;
  assign w_passive_now = (processor_status == 3'b111);
  // Passive status must be seen on two consecutive ticks before the bus is idle.
  assign w_bus_idle    = w_passive_now & passive_q;

  // Edge history every clock; FSM, counters and passive history only on a tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_cpu_clock_q <= 1'b0;
      passive_q        <= 1'b0;
      state_q          <= ST_CPU_OWN;
      cnt_q            <= 4'd0;
      tcnt_q           <= 16'd0;
    end else begin
      prev_cpu_clock_q <= cpu_clock;
      if (w_tick) begin
        passive_q <= w_passive_now;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        tcnt_q    <= tcnt_d;
      end
    end
  end

  // Next-state, counter updates and Moore output decode.
  always_comb begin
    state_d              = state_q;
    cnt_d                = cnt_q;
    tcnt_d               = tcnt_q;
    address_enable_n     = 1'b0;
    command_enable       = 1'b1;
    dma_hold_acknowledge = 1'b0;
    cpu_ready            = 1'b1;

    case (state_q)
      ST_CPU_OWN: begin
        if (dma_hold_request && lock_n && w_bus_idle) begin
          state_d = ST_RELEASE;
          cnt_d   = c_HANDOVER_LOAD;
        end
      end

      ST_RELEASE: begin
        command_enable = 1'b0;
        cpu_ready      = 1'b0;
        // A dropped request, a new CPU cycle or a lock aborts the handover,
        // and takes priority over the counter running out.
        if (!dma_hold_request || !w_passive_now || !lock_n) begin
          state_d = ST_CPU_OWN;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_DMA_OWN;
          tcnt_d  = 16'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DMA_OWN: begin
        address_enable_n     = 1'b1;
        command_enable       = 1'b0;
        dma_hold_acknowledge = 1'b1;
        cpu_ready            = 1'b0;
        if (!dma_hold_request) begin
          state_d = ST_RECLAIM;
          cnt_d   = c_RETURN_LOAD;
          tcnt_d  = 16'd0;
        end else if (tcnt_q != 16'hFFFF) begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end

      ST_RECLAIM: begin
        address_enable_n = 1'b1;
        command_enable   = 1'b0;
        cpu_ready        = 1'b0;
        // A fresh request here is ignored; it is re-arbitrated from CPU_OWN.
        if (cnt_q == 4'd0) begin
          state_d = ST_CPU_OWN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_CPU_OWN;
      end
    endcase
  end

  assign dma_timeout = (state_q == ST_DMA_OWN) & c_TIMEOUT_EN & (tcnt_q >= c_TIMEOUT);
  assign bus_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_kf8288_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_kf8288_bus_arbiter
// Description : Randomised self-checking bench for kf8288_bus_arbiter with a
//               tick-level ownership model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kf8288_bus_arbiter;

  localparam int HANDOVER = 2;
  localparam int RETURN_C = 1;
  localparam int TIMEOUT  = 5;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_clock = 1'b0;
  logic [2:0] processor_status = 3'b111;
  logic       lock_n = 1'b1;
  logic       dma_hold_request = 1'b0;
  logic       dma_hold_acknowledge;
  logic       address_enable_n;
  logic       command_enable;
  logic       cpu_ready;
  logic       dma_timeout;
  logic [1:0] bus_state;

  int vectors = 0;
  int miscompares = 0;

  kf8288_bus_arbiter #(
    .HANDOVER_CYCLES(HANDOVER),
    .RETURN_CYCLES  (RETURN_C),
    .DMA_TIMEOUT    (TIMEOUT)
  ) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .cpu_clock           (cpu_clock),
    .processor_status    (processor_status),
    .lock_n              (lock_n),
    .dma_hold_request    (dma_hold_request),
    .dma_hold_acknowledge(dma_hold_acknowledge),
    .address_enable_n    (address_enable_n),
    .command_enable      (command_enable),
    .cpu_ready           (cpu_ready),
    .dma_timeout         (dma_timeout),
    .bus_state           (bus_state)
  );

  always #5 clock = ~clock;

  // ---------------- reference model (one call per cpu_clock rise) ----------
  // Owner: 0 CPU, 1 releasing, 2 DMA, 3 reclaiming. Time spent in each
  // phase is counted upward and compared with the configured length.
  int m_owner;
  bit m_last_passive;
  int m_rel_ticks;
  int m_rec_ticks;
  int m_dma_ticks;

  function automatic void model_reset();
    m_owner = 0; m_last_passive = 0;
    m_rel_ticks = 0; m_rec_ticks = 0; m_dma_ticks = 0;
  endfunction

  function automatic void model_step(input bit hrq, input bit lk, input logic [2:0] ps);
    bit passive = (ps == 3'b111);
    bit idle    = passive && m_last_passive;
    case (m_owner)
      0: if (hrq && lk && idle) begin m_owner = 1; m_rel_ticks = 0; end
      1: if (!hrq || !passive || !lk) m_owner = 0;
         else begin
           m_rel_ticks++;
           if (m_rel_ticks == HANDOVER) begin m_owner = 2; m_dma_ticks = 0; end
         end
      2: if (!hrq) begin m_owner = 3; m_rec_ticks = 0; end
         else if (m_dma_ticks < 65535) m_dma_ticks++;
      default: begin
        m_rec_ticks++;
        if (m_rec_ticks == RETURN_C) m_owner = 0;
      end
    endcase
    m_last_passive = passive;
  endfunction

  // Packed expectation {hlda, aen_n, cen, cpu_ready, timeout, state}.
  function automatic logic [6:0] exp_vec();
    logic to = (m_owner == 2) && (TIMEOUT != 0) && (m_dma_ticks >= TIMEOUT);
    return {m_owner == 2, m_owner >= 2, m_owner == 0, m_owner == 0, to, 2'(m_owner)};
  endfunction

  function automatic logic [6:0] dut_vec();
    return {dma_hold_acknowledge, address_enable_n, command_enable, cpu_ready,
            dma_timeout, bus_state};
  endfunction

  // ---------------- stimulus -----------------------------------------------
  // One cpu_clock period: random-length low phase with junk inputs, then a
  // rise with the real inputs, returning just after the consuming edge.
  task automatic tick(input bit hrq, input bit lk, input logic [2:0] ps);
    repeat ($urandom_range(1, 3)) begin
      @(negedge clock);
      cpu_clock        = 1'b0;
      dma_hold_request = 1'($urandom);
      lock_n           = 1'($urandom);
      processor_status = 3'($urandom);
    end
    @(negedge clock);
    dma_hold_request = hrq;
    lock_n           = lk;
    processor_status = ps;
    cpu_clock        = 1'b1;
    model_step(hrq, lk, ps);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    cpu_clock = 1'b0;
    repeat (3) @(negedge clock);
    model_reset();
    reset_n = 1'b1;
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    apply_reset();
    vectors++;
    if (dut_vec() !== 7'b0011000) begin
      miscompares++;
      $display("FAIL reset_state got %b want %b", dut_vec(), 7'b0011000);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 3'b111);
      vectors++;
      if (dut_vec() !== 7'b0011000 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle tick%0d got %b want %b", i, dut_vec(), 7'b0011000);
      end
    end
  endtask

  task automatic test_handover();
    logic [1:0] want [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 3'b111);
      vectors++;
      if (bus_state !== want[i] || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL handover tick%0d got %b want %b (state %0d)",
                 i + 1, dut_vec(), exp_vec(), want[i]);
      end
    end
    vectors++;
    if (dma_hold_acknowledge !== 1'b1 || address_enable_n !== 1'b1) begin
      miscompares++;
      $display("FAIL handover_grant got hlda=%b aen_n=%b want 1 1",
               dma_hold_acknowledge, address_enable_n);
    end
    tick(1'b0, 1'b1, 3'b111);
    vectors++;
    if (bus_state !== 2'd3 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL return_reclaim got %b want %b", dut_vec(), exp_vec());
    end
    tick(1'b0, 1'b1, 3'b111);
    vectors++;
    if (bus_state !== 2'd0 || command_enable !== 1'b1 || cpu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL return_cpu got %b want %b", dut_vec(), 7'b0011000);
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 3'b111);
      vectors++;
      if (bus_state !== 2'd0 || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL lock_block tick%0d got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 3'b111);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL lock_release tick%0d got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    vectors++;
    if (dma_hold_acknowledge !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_grant got hlda=%b want 1", dma_hold_acknowledge);
    end
    tick(1'b0, 1'b1, 3'b111);
    tick(1'b0, 1'b1, 3'b111);
  endtask

  task automatic test_abort();
    apply_reset();
    tick(1'b1, 1'b1, 3'b111);
    tick(1'b1, 1'b1, 3'b111);
    vectors++;
    if (bus_state !== 2'd1) begin
      miscompares++;
      $display("FAIL abort_setup got state %0d want 1", bus_state);
    end
    tick(1'b1, 1'b1, 3'b101);
    vectors++;
    if (bus_state !== 2'd0 || dma_hold_acknowledge !== 1'b0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL abort_status got %b want %b", dut_vec(), 7'b0011000);
    end
    tick(1'b1, 1'b1, 3'b111);
    vectors++;
    if (bus_state !== 2'd0) begin
      miscompares++;
      $display("FAIL abort_one_passive got state %0d want 0", bus_state);
    end
    tick(1'b1, 1'b1, 3'b111);
    vectors++;
    if (bus_state !== 2'd1 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL abort_reenter got %b want %b", dut_vec(), exp_vec());
    end
    tick(1'b0, 1'b1, 3'b111);
    vectors++;
    if (bus_state !== 2'd0 || dut_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL abort_hrq_drop got %b want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_timeout();
    while (m_owner != 2) tick(1'b1, 1'b1, 3'b111);
    for (int k = 1; k <= 7; k++) begin
      tick(1'b1, 1'b1, 3'b111);
      vectors++;
      if (dma_timeout !== (k >= TIMEOUT) || dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL timeout dma_tick%0d got %b want %b", k, dut_vec(), exp_vec());
      end
    end
    tick(1'b0, 1'b1, 3'b111);
    vectors++;
    if (dma_timeout !== 1'b0 || bus_state !== 2'd3) begin
      miscompares++;
      $display("FAIL timeout_clear got to=%b state=%0d want 0 3", dma_timeout, bus_state);
    end
    tick(1'b0, 1'b1, 3'b111);
  endtask

  task automatic test_mid_dma_reset();
    int guard = 0;
    while (m_owner != 2 && guard < 20) begin tick(1'b1, 1'b1, 3'b111); guard++; end
    vectors++;
    if (dma_hold_acknowledge !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_setup got hlda=%b want 1", dma_hold_acknowledge);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({dma_hold_acknowledge, address_enable_n, command_enable} !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_reset_async got hlda/aen_n/cen=%b want 001",
               {dma_hold_acknowledge, address_enable_n, command_enable});
    end
    model_reset();
    cpu_clock = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_stuck();
    logic [6:0] held;
    while (m_owner != 1) tick(1'b1, 1'b1, 3'b111);
    held = exp_vec();
    for (int lvl = 1; lvl >= 0; lvl--) begin
      for (int i = 0; i < 12; i++) begin
        @(negedge clock);
        cpu_clock        = 1'(lvl);
        dma_hold_request = 1'($urandom);
        lock_n           = 1'($urandom);
        processor_status = 3'($urandom);
      end
      vectors++;
      if (dut_vec() !== held) begin
        miscompares++;
        $display("FAIL stuck_level%0d got %b want %b", lvl, dut_vec(), held);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit         hrq = ($urandom_range(0, 9) < 7);
      bit         lk  = ($urandom_range(0, 9) < 8);
      logic [2:0] ps  = ($urandom_range(0, 9) < 8) ? 3'b111 : 3'($urandom);
      tick(hrq, lk, ps);
      vectors++;
      if (dut_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random tick%0d got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_handover();
    test_lock();
    test_abort();
    test_timeout();
    test_mid_dma_reset();
    test_stuck();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/kf8288_bus_arbiter.md
Name: kf8288_bus_arbiter

Overview:
- Hands system-bus ownership between the CPU, whose commands go through the KF8288 bus controller, and the DMA controller hold request.
- Drives the bus controller's address_enable_n and command_enable, returns hold acknowledge to DMA, and throttles the CPU through cpu_ready.
- Sequences every handover on cpu_clock rising edges, which are detected in the fast clock domain. Sits between the 8288, the 8237 and the CPU ready logic.

Parameters:
HANDOVER_CYCLES, 2, cpu_clock periods in RELEASE before DMA gets the bus (1..15)
RETURN_CYCLES, 1, cpu_clock periods in RECLAIM before the CPU regains the bus (1..15)
DMA_TIMEOUT, 0, cpu_clock periods of DMA ownership before dma_timeout asserts; 0 disables (0..65535)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset_n  input  1  asynchronous active-low reset
cpu_clock  input  1  CPU clock level, sampled by clock
processor_status  input  3  CPU S2..S0; 3'b111 means passive
lock_n  input  1  CPU bus lock; low blocks any grant
dma_hold_request  input  1  HRQ from the DMA controller
dma_hold_acknowledge  output  1  HLDA to the DMA controller
address_enable_n  output  1  AEN to the bus controller; high means DMA drives the bus
command_enable  output  1  CEN to the bus controller
cpu_ready  output  1  low holds the CPU off the bus during handover and DMA ownership
dma_timeout  output  1  DMA ownership has exceeded DMA_TIMEOUT
bus_state  output  2  current state encoding, for debug

Behaviour:
- One clock and one reset: clock is the single clock, reset_n is asynchronous and active-low. All registers clear immediately when reset_n goes low.
- Edge detect:
  - prev_cpu_clock register, reset value 0.
  - tick = ~prev_cpu_clock & cpu_clock.
  - All state, counter and passive-history updates happen only on clock edges where tick=1.
- bus_idle = (processor_status==3'b111) & passive_d.
  - passive_d is processor_status==3'b111 registered on the previous tick; reset value 0.
  - In other words, two consecutive ticks must see passive status.
- States, with Moore outputs decoded from the state register:
  - CPU_OWN (0): address_enable_n=0, command_enable=1, dma_hold_acknowledge=0, cpu_ready=1.
  - RELEASE (1): address_enable_n=0, command_enable=0, dma_hold_acknowledge=0, cpu_ready=0.
  - DMA_OWN (2): address_enable_n=1, command_enable=0, dma_hold_acknowledge=1, cpu_ready=0.
  - RECLAIM (3): address_enable_n=1, command_enable=0, dma_hold_acknowledge=0, cpu_ready=0.
- Reset values: state=CPU_OWN, so outputs are AEN_n=0, CEN=1, HLDA=0, cpu_ready=1, dma_timeout=0, bus_state=0. All counters are 0.
- Transitions on each tick:
  - CPU_OWN -> RELEASE when dma_hold_request & lock_n & bus_idle. Load cnt=HANDOVER_CYCLES-1.
  - RELEASE -> CPU_OWN (abort) when ~dma_hold_request, or processor_status!=3'b111 (CPU started a cycle), or ~lock_n. The request is re-evaluated on later ticks.
  - Otherwise, RELEASE -> DMA_OWN when cnt==0; else cnt decrements.
  - Abort has priority over counter expiry.
  - DMA_OWN -> RECLAIM when ~dma_hold_request. Load cnt=RETURN_CYCLES-1 and clear tcnt.
  - Otherwise in DMA_OWN, tcnt (16-bit) increments and saturates at 16'hFFFF.
  - RECLAIM -> CPU_OWN when cnt==0; else cnt decrements. dma_hold_request re-asserting in RECLAIM is ignored until CPU_OWN is reached and bus_idle holds again.
- cnt is 4 bits wide.
- dma_timeout is combinational: (state==DMA_OWN) & (DMA_TIMEOUT!=0) & (tcnt>=DMA_TIMEOUT).
  - tcnt clears on entry to DMA_OWN.
  - When the request drop and the timeout coincide, the design goes to RECLAIM and dma_timeout falls with the state change.
- Latency: outputs change on the same clock edge that consumes the tick, i.e. one clock after the rising cpu_clock level is first seen.
  - Request to HLDA = 1 + HANDOVER_CYCLES ticks, counted from the tick on which bus_idle holds.
- cpu_clock stuck high or low: no ticks occur and the state freezes.
- Reset asserted in any state, including mid-DMA: returns at once to CPU_OWN outputs. HLDA drops asynchronously.

Test Plan:
- Reset then idle: hold reset_n=0, then release with status=111 and no request. Required: AEN_n=0, CEN=1, HLDA=0, cpu_ready=1, bus_state=0 throughout.
- Basic handover (HANDOVER=2, RETURN=1): status held at 111, HRQ=1. Required:
  - RELEASE on the 2nd tick.
  - DMA_OWN (HLDA=1, AEN_n=1) on the 4th tick.
  - After HRQ drops: RECLAIM on the next tick, CPU_OWN (CEN=1, cpu_ready=1) one tick later.
- Lock blocking: HRQ=1 with lock_n=0 for 10 ticks. Required: stays in CPU_OWN. After lock_n goes to 1, grant follows in 3 ticks.
- Abort: in RELEASE, drive status=101 on a tick. Required: back to CPU_OWN on that tick, HLDA never asserted. After status returns to 111 for two ticks, RELEASE re-entered.
- Timeout (DMA_TIMEOUT=5): hold the bus in DMA_OWN. Required: dma_timeout=1 after 5 DMA ticks. It clears on the tick HRQ drops.
- Mid-DMA reset: pulse reset_n low while in DMA_OWN. Required: HLDA=0, AEN_n=0, CEN=1 immediately, without waiting for a clock.
